// File: rtl/buzzer_tone_driver.sv
// Piezo buzzer tone driver.
// Plays one of three fixed-pitch square-wave tones in bursts of ON_CYCLES
// separated by OFF_CYCLES gaps. The highest requesting channel wins. The
// channel is latched for a whole burst plus its gap, and every burst that
// starts runs to completion.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | silent, no channel latched, waiting for a nonzero buzz_req
// TONE_ON  | burst in progress, tone_out toggles every HALFk cycles
// TONE_OFF | inter-burst gap, tone_out low, buzz_req resampled at the end
module buzzer_tone_driver #(
    parameter int HALF1      = 12,
    parameter int HALF2      = 8,
    parameter int HALF3      = 4,
    parameter int ON_CYCLES  = 48,
    parameter int OFF_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] buzz_req,
    output logic       tone_out,
    output logic [1:0] chan_active,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TONE_ON  = 2'd1,
        TONE_OFF = 2'd2
    } state_t;

    localparam logic [7:0] HALF1_TC = 8'(HALF1 - 1);
    localparam logic [7:0] HALF2_TC = 8'(HALF2 - 1);
    localparam logic [7:0] HALF3_TC = 8'(HALF3 - 1);
    localparam logic [7:0] ON_TC    = 8'(ON_CYCLES - 1);
    localparam logic [7:0] OFF_TC   = 8'(OFF_CYCLES - 1);

    state_t     state, state_nxt;
    logic       tone_nxt;
    logic [1:0] chan_nxt;
    logic [7:0] half_cnt, half_nxt;
    logic [7:0] cad_cnt, cad_nxt;
    logic [7:0] half_tc;
    logic [1:0] chan_sel;
    logic       req_any;

    // Priority select: highest set request bit names the channel.
    always_comb begin
        chan_sel = 2'd0;
        if (buzz_req[2])      chan_sel = 2'd3;
        else if (buzz_req[1]) chan_sel = 2'd2;
        else if (buzz_req[0]) chan_sel = 2'd1;
    end

    assign req_any = |buzz_req;

    // Half-period terminal count for the latched channel.
    always_comb begin
        case (chan_active)
            2'd1:    half_tc = HALF1_TC;
            2'd2:    half_tc = HALF2_TC;
            default: half_tc = HALF3_TC;
        endcase
    end

    // State register and registered outputs/counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tone_out    <= 1'b0;
            chan_active <= 2'd0;
            half_cnt    <= 8'd0;
            cad_cnt     <= 8'd0;
        end else begin
            state       <= state_nxt;
            tone_out    <= tone_nxt;
            chan_active <= chan_nxt;
            half_cnt    <= half_nxt;
            cad_cnt     <= cad_nxt;
        end
    end

    // Next-state, tone and counter logic.
    always_comb begin
        state_nxt = state;
        tone_nxt  = tone_out;
        chan_nxt  = chan_active;
        half_nxt  = half_cnt;
        cad_nxt   = cad_cnt;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = TONE_ON;
                    tone_nxt  = 1'b1;
                    chan_nxt  = chan_sel;
                    half_nxt  = 8'd0;
                    cad_nxt   = 8'd0;
                end
            end
            TONE_ON: begin
                if (half_cnt == half_tc) begin
                    half_nxt = 8'd0;
                    tone_nxt = ~tone_out;
                end else begin
                    half_nxt = half_cnt + 8'd1;
                end
                // Burst end overrides the tone toggle; the request level is
                // only consulted here, so a dropped request never cuts a burst.
                if (cad_cnt == ON_TC) begin
                    tone_nxt = 1'b0;
                    half_nxt = 8'd0;
                    cad_nxt  = 8'd0;
                    if (req_any) begin
                        state_nxt = TONE_OFF;
                    end else begin
                        state_nxt = IDLE;
                        chan_nxt  = 2'd0;
                    end
                end else begin
                    cad_nxt = cad_cnt + 8'd1;
                end
            end
            TONE_OFF: begin
                tone_nxt = 1'b0;
                if (cad_cnt == OFF_TC) begin
                    cad_nxt  = 8'd0;
                    half_nxt = 8'd0;
                    if (req_any) begin
                        state_nxt = TONE_ON;
                        tone_nxt  = 1'b1;
                        chan_nxt  = chan_sel;
                    end else begin
                        state_nxt = IDLE;
                        chan_nxt  = 2'd0;
                    end
                end else begin
                    cad_nxt = cad_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tone_nxt  = 1'b0;
                chan_nxt  = 2'd0;
                half_nxt  = 8'd0;
                cad_nxt   = 8'd0;
            end
        endcase
    end

    // busy is a pure decode of the state register.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_buzzer_tone_driver.sv
// Directed bench for buzzer_tone_driver with default parameters.
// Inputs change 1 ns after a rising edge; outputs are checked at the same
// point, so "k" below counts rising edges since entry to TONE_ON (k=0 is
// the entry edge itself).
module tb_buzzer_tone_driver;

    logic       clk;
    logic       rst_n;
    logic [2:0] buzz_req;
    logic       tone_out;
    logic [1:0] chan_active;
    logic       busy;

    int vectors;
    int miscompares;

    buzzer_tone_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .buzz_req    (buzz_req),
        .tone_out    (tone_out),
        .chan_active (chan_active),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tone k edges into a burst+gap cycle with the given half-period
    // (48-cycle burst, then low).
    function automatic logic exp_tone(input int k, input int half);
        return (k < 48) && (((k / half) % 2) == 0);
    endfunction

    task automatic chk_outs(input string tag, input logic t, input logic [1:0] c, input logic b);
        chk({tag, " tone"}, {7'd0, tone_out}, {7'd0, t});
        chk({tag, " chan"}, {6'd0, chan_active}, {6'd0, c});
        chk({tag, " busy"}, {7'd0, busy}, {7'd0, b});
    endtask

    // Hold reset across two clock edges with req already applied; release
    // just after an edge so the next edge is the first normal IDLE sample.
    task automatic do_reset(input logic [2:0] req);
        rst_n = 1'b0;
        #1;
        chk_outs("rst_async", 1'b0, 2'd0, 1'b0);
        buzz_req = req;
        tick();
        tick();
        chk_outs("rst_held", 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        buzz_req    = 3'b000;
        #2;

        // Channel 1 held, then switch to channel 3 at cycle 10 of burst 2.
        do_reset(3'b001);
        tick();
        for (int k = 0; k < 64; k++) begin
            chk_outs($sformatf("ch1 b1 k=%0d", k), exp_tone(k, 12), 2'd1, 1'b1);
            tick();
        end
        for (int k = 0; k < 64; k++) begin
            if (k == 10) buzz_req = 3'b100;
            chk_outs($sformatf("ch1 b2 k=%0d", k), exp_tone(k, 12), 2'd1, 1'b1);
            tick();
        end
        for (int k = 0; k < 64; k++) begin
            chk_outs($sformatf("ch3 after switch k=%0d", k), exp_tone(k, 4), 2'd3, 1'b1);
            tick();
        end

        // Channel 3 via 101, request dropped during the gap.
        do_reset(3'b101);
        tick();
        for (int k = 0; k < 64; k++) begin
            if (k == 50) buzz_req = 3'b000;
            chk_outs($sformatf("ch3 drop k=%0d", k), exp_tone(k, 4), 2'd3, 1'b1);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            chk_outs($sformatf("idle after gap k=%0d", k), 1'b0, 2'd0, 1'b0);
            tick();
        end

        // One-cycle pulse on channel 2: one full burst, no gap.
        do_reset(3'b010);
        tick();
        buzz_req = 3'b000;
        for (int k = 0; k < 48; k++) begin
            chk_outs($sformatf("ch2 pulse k=%0d", k), exp_tone(k, 8), 2'd2, 1'b1);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            chk_outs($sformatf("idle after pulse k=%0d", k), 1'b0, 2'd0, 1'b0);
            tick();
        end

        // Reset mid-burst on channel 2, then clean restart on channel 1.
        do_reset(3'b010);
        tick();
        for (int k = 0; k < 20; k++) begin
            chk_outs($sformatf("ch2 pre-rst k=%0d", k), exp_tone(k, 8), 2'd2, 1'b1);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk_outs("mid-burst rst", 1'b0, 2'd0, 1'b0);
        buzz_req = 3'b001;
        #1;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 30; k++) begin
            chk_outs($sformatf("ch1 restart k=%0d", k), exp_tone(k, 12), 2'd1, 1'b1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
